// File: rtl/dark_btn_pkg.sv
// dark_btn_pkg: shared definitions for the push-button input path.
//   LVL_LSB / PEND_LSB / OVF_LSB : bit offsets of the fields in the status word
//   MAX_NBTN                     : widest supported button vector
//   pack_status()                : builds the 32-bit status word from
//                                  MAX_NBTN-wide (zero-extended) fields
package dark_btn_pkg;

   localparam int unsigned LVL_LSB  = 0;
   localparam int unsigned PEND_LSB = 8;
   localparam int unsigned OVF_LSB  = 16;
   localparam int unsigned MAX_NBTN = 8;

   function automatic logic [31:0] pack_status(
      input logic [MAX_NBTN-1:0] lvl,
      input logic [MAX_NBTN-1:0] pend,
      input logic [MAX_NBTN-1:0] ovf
   );
      logic [31:0] w;
      w = '0;
      w[LVL_LSB  +: MAX_NBTN] = lvl;
      w[PEND_LSB +: MAX_NBTN] = pend;
      w[OVF_LSB  +: MAX_NBTN] = ovf;
      return w;
   endfunction

endpackage

// File: rtl/dark_debounce.sv
// dark_debounce: one button bit -- synchronizer, debounce counter and
// stable-level flop.
//   XCLK  : system clock
//   XRES  : synchronous active-low reset
//   raw   : asynchronous button level (1 = pressed)
//   level : debounced stable level
//   rise  : high in the cycle whose closing edge takes level from 0 to 1
module dark_debounce
   import dark_btn_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic XCLK,
   input  logic XRES,
   input  logic raw,
   output logic level,
   output logic rise
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CW-1:0]          cnt_q;
   logic                   synced;
   logic                   accept;

   assign synced = sync_q[SYNC_STAGES-1];
   // The counter has seen DEBOUNCE_CYCLES-1 mismatches; this one is the last.
   assign accept = (synced != level) && (cnt_q == CNT_MAX);
   // Decoded from registers so the owner can flag the press on the very
   // edge that updates level.
   assign rise   = accept && synced;

   always_ff @(posedge XCLK) begin
      if (!XRES) begin
         sync_q <= '0;
         cnt_q  <= '0;
         level  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
         if (synced == level) begin
            cnt_q <= '0;
         end else if (accept) begin
            level <= synced;
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dark_btn_in.sv
// dark_btn_in: push-button/switch input block. Synchronizes and debounces
// each button, latches press events as sticky pending flags (with an
// overflow flag for a second press before the first was consumed), and
// exposes them through a one-cycle read handshake that clears what it reads.
//   XCLK      : system clock (divided SoC clock)
//   XRES      : synchronous active-low reset
//   btn_raw   : asynchronous button levels, 1 = pressed
//   btn_level : debounced levels
//   rd_req    : read request, sampled every rising edge
//   rd_ack    : one-cycle pulse in the cycle after a sampled rd_req
//   rd_data   : {ovf @16, pend @8, level @0} snapshot, 0 when rd_ack=0
//   irq       : high while any pending flag is set
module dark_btn_in
   import dark_btn_pkg::*;
#(
   parameter int unsigned NBTN            = 4,
   parameter int unsigned SYNC_STAGES     = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 16
) (
   input  logic            XCLK,
   input  logic            XRES,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   input  logic            rd_req,
   output logic            rd_ack,
   output logic [31:0]     rd_data,
   output logic            irq
);

   logic [NBTN-1:0]     rise;
   logic [NBTN-1:0]     pend_q;
   logic [NBTN-1:0]     ovf_q;
   logic [MAX_NBTN-1:0] lvl_x;
   logic [MAX_NBTN-1:0] pend_x;
   logic [MAX_NBTN-1:0] ovf_x;

   for (genvar g = 0; g < NBTN; g++) begin : g_btn
      dark_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_deb (
         .XCLK  (XCLK),
         .XRES  (XRES),
         .raw   (btn_raw[g]),
         .level (btn_level[g]),
         .rise  (rise[g])
      );
   end

   always_comb begin
      lvl_x             = '0;
      pend_x            = '0;
      ovf_x             = '0;
      lvl_x[NBTN-1:0]   = btn_level;
      pend_x[NBTN-1:0]  = pend_q;
      ovf_x[NBTN-1:0]   = ovf_q;
   end

   assign irq = |pend_q;

   always_ff @(posedge XCLK) begin
      if (!XRES) begin
         pend_q  <= '0;
         ovf_q   <= '0;
         rd_ack  <= 1'b0;
         rd_data <= '0;
      end else begin
         rd_ack  <= rd_req;
         rd_data <= rd_req ? pack_status(lvl_x, pend_x, ovf_x) : '0;
         // A read consumes the old flags; a press on the same edge survives
         // the clear, and it is not an overflow because the old flag is
         // being handed to the reader.
         if (rd_req) begin
            pend_q <= rise;
            ovf_q  <= '0;
         end else begin
            pend_q <= pend_q | rise;
            ovf_q  <= ovf_q | (rise & pend_q);
         end
      end
   end

endmodule

// File: tb/tb_dark_btn_in.sv
// tb_dark_btn_in: directed, table-driven bench for dark_btn_in with
// NBTN=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4 (6-edge press latency).
module tb_dark_btn_in;

   logic        XCLK;
   logic        XRES;
   logic [3:0]  btn_raw;
   logic [3:0]  btn_level;
   logic        rd_req;
   logic        rd_ack;
   logic [31:0] rd_data;
   logic        irq;

   int checks = 0;
   int errors = 0;

   dark_btn_in #(
      .NBTN            (4),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .XCLK      (XCLK),
      .XRES      (XRES),
      .btn_raw   (btn_raw),
      .btn_level (btn_level),
      .rd_req    (rd_req),
      .rd_ack    (rd_ack),
      .rd_data   (rd_data),
      .irq       (irq)
   );

   initial XCLK = 1'b0;
   always #5 XCLK = ~XCLK;

   typedef struct {
      logic        rst_n;
      logic [3:0]  raw;
      logic        req;
      logic [3:0]  lvl;
      logic        irq;
      logic        ack;
      logic [31:0] data;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input int n, input logic rst_n, input logic [3:0] raw,
                      input logic req, input logic [3:0] lvl, input logic i,
                      input logic ack, input logic [31:0] data);
      vec_t v;
      v.rst_n = rst_n; v.raw = raw; v.req = req;
      v.lvl = lvl; v.irq = i; v.ack = ack; v.data = data;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, then sample 1 time unit later.
   task automatic step(input logic rst_n, input logic [3:0] raw, input logic req);
      XRES = rst_n; btn_raw = raw; rd_req = req;
      @(posedge XCLK);
      #1;
   endtask

   task automatic step_n(input int n, input logic [3:0] raw);
      for (int k = 0; k < n; k++) step(1'b1, raw, 1'b0);
   endtask

   initial begin
      XRES = 1'b0; btn_raw = '0; rd_req = 1'b0;

      //   n  rst raw   req lvl   irq ack data
      // reset hold with all buttons pressed, then release of reset
      add(10, 0, 4'hF, 0, 4'h0, 0, 0, 32'h0);
      add(5,  1, 4'hF, 0, 4'h0, 0, 0, 32'h0);
      add(1,  1, 4'hF, 0, 4'hF, 1, 0, 32'h0);
      add(1,  1, 4'hF, 1, 4'hF, 0, 1, 32'h0000_0F0F);
      add(1,  1, 4'hF, 0, 4'hF, 0, 0, 32'h0);
      // release: level falls after 6 edges, no event
      add(5,  1, 4'h0, 0, 4'hF, 0, 0, 32'h0);
      add(1,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);
      // clean press on bit 1, then two back-to-back reads
      add(5,  1, 4'h2, 0, 4'h0, 0, 0, 32'h0);
      add(1,  1, 4'h2, 0, 4'h2, 1, 0, 32'h0);
      add(1,  1, 4'h2, 1, 4'h2, 0, 1, 32'h0000_0202);
      add(1,  1, 4'h2, 1, 4'h2, 0, 1, 32'h0000_0002);
      add(1,  1, 4'h2, 0, 4'h2, 0, 0, 32'h0);
      add(5,  1, 4'h0, 0, 4'h2, 0, 0, 32'h0);
      add(1,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);
      // 3-cycle glitch on bit 0 is rejected
      add(3,  1, 4'h1, 0, 4'h0, 0, 0, 32'h0);
      add(6,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);
      add(1,  1, 4'h0, 1, 4'h0, 0, 1, 32'h0);
      add(1,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);
      // 4-cycle pulse on bit 0 is accepted, then released
      add(4,  1, 4'h1, 0, 4'h0, 0, 0, 32'h0);
      add(1,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);
      add(4,  1, 4'h0, 0, 4'h1, 1, 0, 32'h0);
      add(1,  1, 4'h0, 0, 4'h0, 1, 0, 32'h0);
      add(1,  1, 4'h0, 1, 4'h0, 0, 1, 32'h0000_0100);
      add(1,  1, 4'h0, 0, 4'h0, 0, 0, 32'h0);

      foreach (vecs[i]) begin
         step(vecs[i].rst_n, vecs[i].raw, vecs[i].req);
         chk($sformatf("v%0d_level", i), 32'(btn_level), 32'(vecs[i].lvl));
         chk($sformatf("v%0d_irq",   i), 32'(irq),       32'(vecs[i].irq));
         chk($sformatf("v%0d_ack",   i), 32'(rd_ack),    32'(vecs[i].ack));
         chk($sformatf("v%0d_data",  i), rd_data,        vecs[i].data);
      end

      // Overflow: two presses on bit 2 with no read in between
      step_n(6, 4'h4);
      chk("ovf_press1_level", 32'(btn_level), 32'h4);
      chk("ovf_press1_irq",   32'(irq),       32'h1);
      step_n(2, 4'h4);
      step_n(6, 4'h0);
      chk("ovf_rel1_level", 32'(btn_level), 32'h0);
      step_n(6, 4'h4);
      chk("ovf_press2_level", 32'(btn_level), 32'h4);
      step_n(6, 4'h0);
      chk("ovf_rel2_level", 32'(btn_level), 32'h0);
      step(1'b1, 4'h0, 1'b1);
      chk("ovf_read_ack",  32'(rd_ack), 32'h1);
      chk("ovf_read_data", rd_data,     32'h0004_0400);
      chk("ovf_read_irq",  32'(irq),    32'h0);
      step(1'b1, 4'h0, 1'b0);
      step(1'b1, 4'h0, 1'b1);
      chk("ovf_reread_data", rd_data, 32'h0);
      step(1'b1, 4'h0, 1'b0);

      // Collision with pend[3]=0: read on the edge bit 3 becomes pressed
      step_n(5, 4'h8);
      chk("col0_pre_level", 32'(btn_level), 32'h0);
      step(1'b1, 4'h8, 1'b1);
      chk("col0_level", 32'(btn_level), 32'h8);
      chk("col0_ack",   32'(rd_ack),    32'h1);
      chk("col0_data",  rd_data,        32'h0);
      chk("col0_irq",   32'(irq),       32'h1);
      step(1'b1, 4'h8, 1'b0);
      step(1'b1, 4'h8, 1'b1);
      chk("col0_next_data", rd_data,  32'h0000_0808);
      chk("col0_next_irq",  32'(irq), 32'h0);
      step(1'b1, 4'h8, 1'b0);

      // Collision with pend[3]=1 already: consumed, new press survives, no ovf
      step_n(6, 4'h0);
      chk("col1_rel_irq", 32'(irq), 32'h0);
      step_n(6, 4'h8);
      chk("col1_first_irq", 32'(irq), 32'h1);
      step_n(6, 4'h0);
      chk("col1_rel_level", 32'(btn_level), 32'h0);
      step_n(5, 4'h8);
      step(1'b1, 4'h8, 1'b1);
      chk("col1_data", rd_data,  32'h0000_0800);
      chk("col1_irq",  32'(irq), 32'h1);
      step(1'b1, 4'h8, 1'b0);
      step(1'b1, 4'h8, 1'b1);
      chk("col1_next_data", rd_data, 32'h0000_0808);
      step(1'b1, 4'h8, 1'b0);
      step_n(6, 4'h0);

      // Reset in mid-debounce (counter at 3), with a read request pending
      step_n(5, 4'h1);
      chk("rstmid_pre_level", 32'(btn_level), 32'h0);
      step(1'b0, 4'h1, 1'b1);
      chk("rstmid_ack",  32'(rd_ack),    32'h0);
      chk("rstmid_data", rd_data,        32'h0);
      chk("rstmid_lvl",  32'(btn_level), 32'h0);
      step_n(5, 4'h1);
      chk("rstmid_edge5_level", 32'(btn_level), 32'h0);
      step_n(1, 4'h1);
      chk("rstmid_edge6_level", 32'(btn_level), 32'h1);
      chk("rstmid_edge6_irq",   32'(irq),       32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
